// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if
//   Bundles the keypad-side and digit-buffer-side signals of the alarm-clock
//   keypad scan controller.
//
//   rows          4  row returns, active-high, asynchronous to clk
//   columns       3  one-hot column strobe, active-high
//   key           4  code of the last accepted key, held between presses
//   shift         1  one-cycle pulse: digit accepted, key valid this cycle
//   time_button   1  one-cycle pulse: '*' accepted
//   alarm_button  1  one-cycle pulse: '#' accepted
//   clear         1  one-cycle pulse: partial entry timed out
//   digit_count   3  digits in the current entry, 0..4, saturating
//
//   Modports: master = the scan controller, slave = keypad matrix plus the
//   downstream digit buffer.
interface keypad_scan_ctrl_if;
  logic [3:0] rows;
  logic [2:0] columns;
  logic [3:0] key;
  logic       shift;
  logic       time_button;
  logic       alarm_button;
  logic       clear;
  logic [2:0] digit_count;

  modport master (
    input  rows,
    output columns, key, shift, time_button, alarm_button, clear, digit_count
  );

  modport slave (
    output rows,
    input  columns, key, shift, time_button, alarm_button, clear, digit_count
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans a 4x3 keypad one column at a time, debounces the row returns and
//   emits one event per key press. Digits pulse shift, '*' pulses
//   time_button, '#' pulses alarm_button. A partially typed entry is dropped
//   (clear pulse) after TIMEOUT idle cycles.
//
//   Parameters: SCAN_DIV (column dwell, >=3), DEBOUNCE (1..15 equal samples
//   for press and release), TIMEOUT (idle cycles, 16-bit counter).
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous, active-low reset
//     kif        keypad_scan_ctrl_if.master (rows in; columns, key, pulses,
//                digit_count out)
//     dbg_state  current scan FSM state (0 SCAN, 1 DEBOUNCE, 2 HELD,
//                3 RELEASE)
//
//   Output protocol: there is no back-pressure. shift, time_button,
//   alarm_button and clear are single-cycle strobes; at most one of the
//   first three is high in any cycle, and key/digit_count already carry the
//   updated values in that same cycle. The consumer must take the event in
//   that cycle.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  keypad_scan_ctrl_if.master kif,
  output logic [1:0]         dbg_state
);

  localparam int              DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_N       = 4'(DEBOUNCE);
  localparam logic [15:0]     TO_LAST    = 16'(TIMEOUT - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [3:0]    rows_meta, rows_s;
  logic [DW-1:0] dwell;
  logic          sample;
  logic [2:0]    col;
  logic [1:0]    col_idx;
  logic [1:0]    state, state_nx;
  logic [3:0]    lat_row, lat_row_nx;
  logic [1:0]    lat_col, lat_col_nx;
  logic [3:0]    cnt, cnt_nx, cnt_inc;
  logic          advance, fire, row_onehot;

  logic [1:0]    dec_r;
  logic [3:0]    dec_code, r4, c4;
  logic          dec_star, dec_hash, dec_digit;

  logic [3:0]    key_q;
  logic          shift_q, time_q, alarm_q, clear_q;
  logic [2:0]    dcount;
  logic [15:0]   idle;

  // The dwell counter free-runs, so samples fall on a fixed 1-in-SCAN_DIV
  // grid; the column only ever moves right after a sample.
  assign sample     = (dwell == DWELL_LAST);
  assign row_onehot = (rows_s != 4'd0) && ((rows_s & (rows_s - 4'd1)) == 4'd0);
  assign cnt_inc    = cnt + 4'd1;

  always_comb begin
    col_idx = 2'd0;
    if (col[1])      col_idx = 2'd1;
    else if (col[2]) col_idx = 2'd2;
  end

  always_comb begin
    state_nx   = state;
    lat_row_nx = lat_row;
    lat_col_nx = lat_col;
    cnt_nx     = cnt;
    advance    = 1'b0;
    fire       = 1'b0;
    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (row_onehot) begin
            lat_row_nx = rows_s;
            lat_col_nx = col_idx;
            cnt_nx     = 4'd1;
            if (DB_N <= 4'd1) begin
              fire     = 1'b1;
              state_nx = ST_HELD;
            end else begin
              state_nx = ST_DEBOUNCE;
            end
          end else begin
            advance = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (rows_s == lat_row) begin
            cnt_nx = cnt_inc;
            if (cnt_inc >= DB_N) begin
              fire     = 1'b1;
              state_nx = ST_HELD;
            end
          end else begin
            state_nx = ST_SCAN;
            advance  = 1'b1;
          end
        end
        ST_HELD: begin
          // Anything but all-zero keeps the key held; no auto-repeat.
          if (rows_s == 4'd0) begin
            cnt_nx = 4'd1;
            if (DB_N <= 4'd1) begin
              state_nx = ST_SCAN;
              advance  = 1'b1;
            end else begin
              state_nx = ST_RELEASE;
            end
          end
        end
        default: begin
          if (rows_s == 4'd0) begin
            cnt_nx = cnt_inc;
            if (cnt_inc >= DB_N) begin
              state_nx = ST_SCAN;
              advance  = 1'b1;
            end
          end else begin
            state_nx = ST_HELD;
          end
        end
      endcase
    end
  end

  // Decode from the next-latched position so a press accepted straight from
  // SCAN (DEBOUNCE = 1) still gets the right code.
  always_comb begin
    dec_r = 2'd0;
    if (lat_row_nx[1])      dec_r = 2'd1;
    else if (lat_row_nx[2]) dec_r = 2'd2;
    else if (lat_row_nx[3]) dec_r = 2'd3;
    r4        = {2'b00, dec_r};
    c4        = {2'b00, lat_col_nx};
    dec_star  = (dec_r == 2'd3) && (lat_col_nx == 2'd0);
    dec_hash  = (dec_r == 2'd3) && (lat_col_nx == 2'd2);
    dec_digit = !dec_star && !dec_hash;
    if (dec_star)            dec_code = 4'd10;
    else if (dec_hash)       dec_code = 4'd11;
    else if (dec_r == 2'd3)  dec_code = 4'd0;
    else                     dec_code = (r4 << 1) + r4 + c4 + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_meta <= 4'd0;
      rows_s    <= 4'd0;
      dwell     <= '0;
      col       <= 3'b001;
      state     <= ST_SCAN;
      lat_row   <= 4'd0;
      lat_col   <= 2'd0;
      cnt       <= 4'd0;
      key_q     <= 4'd0;
      shift_q   <= 1'b0;
      time_q    <= 1'b0;
      alarm_q   <= 1'b0;
      clear_q   <= 1'b0;
      dcount    <= 3'd0;
      idle      <= 16'd0;
    end else begin
      rows_meta <= kif.rows;
      rows_s    <= rows_meta;
      dwell     <= sample ? '0 : dwell + 1'b1;
      if (advance) col <= {col[1:0], col[2]};
      state     <= state_nx;
      lat_row   <= lat_row_nx;
      lat_col   <= lat_col_nx;
      cnt       <= cnt_nx;

      shift_q   <= fire && dec_digit;
      time_q    <= fire && dec_star;
      alarm_q   <= fire && dec_hash;
      clear_q   <= 1'b0;
      if (fire) key_q <= dec_code;

      // An event on the timeout cycle takes priority over the clear.
      if (fire) begin
        idle <= 16'd0;
        if (dec_digit) dcount <= (dcount == 3'd4) ? 3'd4 : dcount + 3'd1;
        else           dcount <= 3'd0;
      end else if (dcount != 3'd0) begin
        if (idle >= TO_LAST) begin
          clear_q <= 1'b1;
          dcount  <= 3'd0;
          idle    <= 16'd0;
        end else begin
          idle <= idle + 16'd1;
        end
      end else begin
        idle <= 16'd0;
      end
    end
  end

  assign kif.columns      = col;
  assign kif.key          = key_q;
  assign kif.shift        = shift_q;
  assign kif.time_button  = time_q;
  assign kif.alarm_button = alarm_q;
  assign kif.clear        = clear_q;
  assign kif.digit_count  = dcount;
  assign dbg_state        = state;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int TIMEOUT  = 64;
  localparam int W        = 6;

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] K_DIG      = 2'd0;
  localparam logic [1:0] K_STAR     = 2'd1;
  localparam logic [1:0] K_HASH     = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .kif      (kif),
    .dbg_state(dbg_state)
  );

  // ---------------- keypad emulation ----------------
  logic       pressed = 1'b0;
  logic [1:0] press_r = 2'd0;
  logic [1:0] press_c = 2'd0;
  logic       use_force = 1'b0;
  logic [3:0] force_rows = 4'd0;
  logic [3:0] rows_drv;

  always_comb begin
    rows_drv = 4'd0;
    if (use_force)                         rows_drv = force_rows;
    else if (pressed && kif.columns[press_c]) rows_drv = 4'(1 << press_r);
  end
  assign kif.rows = rows_drv;

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int mdl_count = 0;
  int last_evt = 0;
  int last_shift_cyc = -1;
  int last_clear_cyc = -1;

  function automatic logic [3:0] key_code(input int r, input int c);
    if (r < 3)       return 4'(3 * r + c + 1);
    else if (c == 0) return 4'd10;
    else if (c == 1) return 4'd0;
    else             return 4'd11;
  endfunction

  function automatic logic [1:0] key_kind(input int r, input int c);
    if (r == 3 && c == 0) return K_STAR;
    if (r == 3 && c == 2) return K_HASH;
    return K_DIG;
  endfunction

  // Scoreboard: events are matched in order against the expected queue;
  // the entry count and the timeout deadline follow from the event history.
  initial begin
    logic         evt, exp_clear;
    logic [1:0]   kind_obs;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        mdl_count = 0;
        last_evt  = cyc;
      end else begin
        evt = kif.shift | kif.time_button | kif.alarm_button;
        if (evt) begin
          check_eq("evt_onehot", 32'(kif.shift) + 32'(kif.time_button) + 32'(kif.alarm_button), 1);
          kind_obs = kif.shift ? K_DIG : (kif.time_button ? K_STAR : K_HASH);
          if (exp_q.size() == 0) begin
            check_eq("evt_pending", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_eq("evt_code", {kind_obs, kif.key}, e);
            if (e[5:4] == K_DIG) mdl_count = (mdl_count >= 4) ? 4 : mdl_count + 1;
            else                 mdl_count = 0;
          end
          last_evt = cyc;
          if (kif.shift) last_shift_cyc = cyc;
        end
        exp_clear = !evt && (mdl_count != 0) && ((cyc - last_evt) == TIMEOUT);
        if (kif.clear || exp_clear) begin
          check_eq("clear", kif.clear, exp_clear);
          if (exp_clear) mdl_count = 0;
        end
        if (kif.clear) last_clear_cyc = cyc;
        check_eq("digit_count", kif.digit_count, mdl_count);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press_key(input int r, input int c, input int hold, input int gap);
    exp_q.push_back({key_kind(r, c), key_code(r, c)});
    press_r = 2'(r);
    press_c = 2'(c);
    pressed = 1'b1;
    repeat (hold) @(negedge clk);
    pressed = 1'b0;
    check_eq("evt_seen", exp_q.size(), 0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, dbg_state, s);
  endtask

  task automatic wait_shift(input int budget);
    int n = 0;
    while (kif.shift !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_shift", kif.shift, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    logic [2:0] seen;
    int c;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_columns", kif.columns, 3'b001);
    check_eq("rst_key", kif.key, 0);
    check_eq("rst_pulses", {kif.shift, kif.time_button, kif.alarm_button, kif.clear}, 0);
    check_eq("rst_count", kif.digit_count, 0);
    check_eq("rst_state", dbg_state, S_SCAN);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // digit decode: key 5 (row 1, column 1), then rotation resumes
    press_key(1, 1, 40, 30);
    seen = 3'b000;
    repeat (12) begin
      @(negedge clk);
      seen = seen | kif.columns;
    end
    check_eq("rotate_after_release", seen, 3'b111);

    // bounce: key 1 drops out on the second sample
    press_r = 2'd0; press_c = 2'd0; pressed = 1'b1;
    wait_state(S_DEBOUNCE, 40, "bounce_enter");
    pressed = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("bounce_abort", dbg_state, S_SCAN);
    repeat (10) @(negedge clk);
    press_key(0, 0, 30, 18);

    // function keys
    press_key(1, 0, 30, 18);  // 4
    press_key(2, 1, 30, 18);  // 8
    press_key(0, 1, 30, 18);  // 2
    press_key(0, 0, 30, 18);  // 1
    check_eq("four_digits", kif.digit_count, 4);
    press_key(3, 0, 30, 18);  // *
    check_eq("star_resets", kif.digit_count, 0);
    press_key(1, 0, 30, 18);
    press_key(2, 1, 30, 18);
    press_key(3, 2, 30, 18);  // #
    check_eq("hash_resets", kif.digit_count, 0);

    // multi-key
    use_force = 1'b1; force_rows = 4'b0110;
    repeat (40) @(negedge clk);
    use_force = 1'b0;
    check_eq("multi_no_lock", dbg_state, S_SCAN);
    repeat (20) @(negedge clk);

    // timeout after single digit 7
    press_key(2, 0, 30, 80);
    check_eq("timeout_gap", last_clear_cyc - last_shift_cyc, TIMEOUT);

    // digit landing exactly on the timeout cycle
    exp_q.push_back({K_DIG, key_code(0, 2)});
    press_r = 2'd0; press_c = 2'd2; pressed = 1'b1;
    wait_shift(60);
    t0 = cyc;
    repeat (2) @(negedge clk);
    pressed = 1'b0;
    while (cyc < t0 + 53) @(negedge clk);
    check_eq("coinc_scan", dbg_state, S_SCAN);
    // Samples sit on a 4-cycle grid ending at t0-1, so cycle t0+55 samples the
    // column driven now; three matching samples put the event on t0+64.
    c = kif.columns[1] ? 1 : (kif.columns[2] ? 2 : 0);
    exp_q.push_back({K_DIG, key_code(1, c)});
    press_r = 2'd1; press_c = 2'(c); pressed = 1'b1;
    while (cyc < t0 + 64) @(negedge clk);
    check_eq("coinc_shift", kif.shift, 1);
    check_eq("coinc_clear", kif.clear, 0);
    check_eq("coinc_count", kif.digit_count, 2);
    repeat (10) @(negedge clk);
    pressed = 1'b0;
    repeat (70) @(negedge clk);
    check_eq("coinc_timeout", last_clear_cyc - last_shift_cyc, TIMEOUT);

    // reset mid-debounce: no event, ever
    press_key(2, 2, 30, 20);  // 9, entry becomes non-empty
    press_r = 2'd1; press_c = 2'd2; pressed = 1'b1;
    wait_state(S_DEBOUNCE, 40, "rst_mid_enter");
    #2 reset = 1'b0;
    #1;
    check_eq("async_columns", kif.columns, 3'b001);
    check_eq("async_pulses", {kif.shift, kif.time_button, kif.alarm_button, kif.clear}, 0);
    check_eq("async_count", kif.digit_count, 0);
    check_eq("async_key", kif.key, 0);
    pressed = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    // held through reset: re-debounced as a new press
    pressed = 1'b1;
    wait_state(S_DEBOUNCE, 40, "rst_held_enter");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.push_back({K_DIG, key_code(1, 2)});
    repeat (40) @(negedge clk);
    pressed = 1'b0;
    check_eq("rst_held_evt", exp_q.size(), 0);
    repeat (20) @(negedge clk);

    // randomized presses, occasional long gaps to hit the timeout
    for (int i = 0; i < 14; i++) begin
      press_key($urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(30, 40), $urandom_range(18, 90));
    end

    check_eq("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the alarm-clock 4x3 keypad. It drives the column strobes, samples and debounces the row returns, and decodes one key per press. For each digit it emits a single-cycle `shift` with the key code to the `keyscan` digit buffer, and it pulses `time_button` or `alarm_button` for the two function keys. It also enforces an entry timeout that clears a partially typed 4-digit entry.

## Interface
- `SCAN_DIV`, 4: clock cycles each column is held (dwell); min 3.
- `DEBOUNCE`, 3: consecutive identical samples required for press and for release; min 1, max 15.
- `TIMEOUT`, 1000: idle cycles after the last digit before a partial entry is cleared; 16-bit counter.
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `rows`  in  4  row returns, active-high; bit r = row r. Asynchronous to `clk`.
- `columns`  out  3  one-hot column strobe, active-high.
- `key`  out  4  decoded code of the last accepted key; holds between presses.
- `shift`  out  1  one-cycle pulse: digit accepted, `key` valid this cycle.
- `time_button`  out  1  one-cycle pulse: `*` accepted.
- `alarm_button`  out  1  one-cycle pulse: `#` accepted.
- `clear`  out  1  one-cycle pulse: partial entry timed out.
- `digit_count`  out  3  digits entered in the current entry, 0..4, saturating.

## Operation
- Rows pass through a 2-flop synchronizer, giving `rows_s`.
- A sample is taken in the last cycle of each dwell (dwell counter = `SCAN_DIV`-1).
- Key map, with r = row and c = column index (0..2):
  - r<3: digit 3r+c+1.
  - r=3, c=0: `*`, code 10.
  - r=3, c=1: digit 0.
  - r=3, c=2: `#`, code 11.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - Columns rotate 001→010→100→001, one step per dwell.
  - At a sample, if `rows_s` is exactly one-hot: latch the column and row, set match count = 1, and go to DEBOUNCE. The column stops rotating.
  - `rows_s` = 0 or multi-hot: rotate and stay in SCAN.
- DEBOUNCE:
  - The column is held. At each sample, if `rows_s` equals the latched row, increment the count.
  - When the count reaches `DEBOUNCE`: emit the event, update `key`, and go to HELD.
  - Any mismatch (including 0 or multi-hot): go to SCAN, advance the column, no event.
- HELD: the column is held. The first sample with `rows_s` = 0 sets release count = 1 and goes to RELEASE. Any other value stays in HELD; no repeat events.
- RELEASE:
  - A sample with `rows_s` = 0 increments the count. At `DEBOUNCE`, go to SCAN and advance the column.
  - A nonzero sample returns to HELD.
- Events:
  - Digit: `shift`=1 for one cycle and `digit_count` increments, saturating at 4. A 5th digit still pulses `shift`.
  - `*`: `time_button` pulse and `digit_count`←0.
  - `#`: `alarm_button` pulse and `digit_count`←0.
- Timeout:
  - The idle counter resets to 0 on every event and increments while `digit_count`≠0.
  - When it reaches `TIMEOUT`: `clear`=1 for one cycle, `digit_count`←0, and the counter resets.
  - While `digit_count`=0 the counter is held at 0.

## Timing
- Reset values (asserted asynchronously when `reset`=0):
  - `columns`=001, `key`=0, `digit_count`=0.
  - `shift`, `time_button`, `alarm_button`, `clear` all 0.
  - FSM=SCAN; all counters 0.
- Reset mid-press: no event is emitted, ever, for a press interrupted by reset. After reset release, scanning restarts at column 0. A still-held key is re-debounced as a new press.
- Timing of the event pulse and `key` update:
  - They occur in the cycle after the `DEBOUNCE`-th matching sample.
  - `key` changes in the same cycle as the pulse.
  - Exactly one of `shift`, `time_button`, `alarm_button` is high in that cycle.
- Minimum press-to-event latency: 2 cycles of synchronizer delay + (`DEBOUNCE`-1)·`SCAN_DIV` cycles after the first matching sample + 1 cycle.
- `columns` changes only on dwell boundaries. The row value sampled belongs to the column driven for at least `SCAN_DIV`-2 cycles.
- If a timeout and an event fall on the same cycle, the event wins: `clear`=0, and the counter and `digit_count` update per the event.
- Idle counter compare is ≥, so wrap is impossible.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE`=3, `TIMEOUT`=64.
- **Reset:** drive `reset`=0 mid-DEBOUNCE → `columns`=001, all pulses 0, `digit_count`=0 immediately (asynchronously); no `shift` follows.
- **Digit decode:** press `rows`=0010 while `columns`=010 is held, 40 cycles, then release → exactly one `shift` with `key`=5, `digit_count`=1; release followed by SCAN rotation.
- **Bounce:** toggle `rows`=0001 in column 0 with a 0 on the second sample → no event, scanning resumes. A following stable press → one `shift` with `key`=1.
- **Function keys:** enter digits 4,8,2,1, then `*` → four `shift` pulses with keys 4,8,2,1, `digit_count`=4, then `time_button` pulse, `digit_count`=0. Repeat with `#` → `alarm_button` pulse.
- **Multi-key and timeout:**
  - `rows`=0110 → no event.
  - Single digit 7 then idle → `clear` pulse exactly 64 cycles after the `shift`; `digit_count`=0.
  - A digit timed to coincide with the timeout → `clear` stays 0.
